seq_alu_module: RTL and testbench
=================================

// Module: seq_alu_module
// PURPOSE
//  Parametrised, multi-cycle successor to the 8-bit combinational calculator ALU.
//  - Same 4-bit opcode map.
//  - Adds a valid/ready handshake on input and output.
//  - Registers the result and adds status flags.
//  - Computes MUL/DIV iteratively (one bit per cycle) to save area at large widths.
//  - Sits between the calculator input/control FSM and the display/result register.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (legal: 2..32)
//  SEL_W  4  opcode width
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        operands and opcode are valid this cycle
//  in_ready   out  1        block can accept an operation (state IDLE)
//  sel        in   SEL_W    opcode, sampled on accept
//  a          in   WIDTH    operand A, sampled on accept
//  b          in   WIDTH    operand B, sampled on accept
//  out_valid  out  1        y/y_hi/flags hold a completed result
//  out_ready  in   1        consumer takes the result this cycle
//  y          out  WIDTH    primary result (low product / quotient)
//  y_hi       out  WIDTH    high product (MUL), remainder (DIV), 0 otherwise
//  flag_zero  out  1        y == 0
//  flag_carry out  1        carry/borrow/shifted-out bit (see below)
//  flag_div0  out  1        DIV with b == 0
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; y, y_hi and all flags = 0.
//    Reset wins over every other input, including mid-MUL/DIV (operation discarded).
//  Accept: in_valid && in_ready at edge N. sel/a/b are latched; later input changes are ignored.
//  FSM: IDLE -> EXEC (MUL/DIV only) -> DONE -> IDLE.
//  - IDLE, non-iterative op accepted: go to DONE; out_valid=1 at N+1.
//  - IDLE, MUL (10) or DIV (11) accepted: go to EXEC with a counter of WIDTH steps.
//    out_valid=1 at N+WIDTH+1.
//  - DIV with b==0: skip EXEC; DONE at N+1 with y=all-ones, y_hi=a, flag_div0=1.
//  - DONE: out_valid=1; y/y_hi/flags held stable. Leave on out_ready=1 -> IDLE.
//  - in_ready=1 only in IDLE. No accept in EXEC/DONE, so in_valid is ignored there.
//    Max throughput: 1 op per 2 cycles.
//  - In EXEC, out_valid=0 and y/y_hi keep their previous values.
//  Ops (all arithmetic modulo 2^WIDTH; W=WIDTH):
//  - 0  y=0
//  - 1  y=~a
//  - 2  y=a<<1, carry=a[W-1]
//  - 3  y=a>>1, carry=a[0]
//  - 4  y=a+1, carry=carry-out (a==all-ones)
//  - 5  y=a&b
//  - 6  y=a|b
//  - 7  y=a^b
//  - 8  y=a+b, carry=carry-out of W-bit add
//  - 9  y=a-b, carry=borrow (a<b unsigned)
//  - 10 {y_hi,y}=a*b unsigned, 2W-bit product; shift-add, one bit of b per cycle
//  - 11 y=a/b, y_hi=a%b unsigned; restoring division, one quotient bit per cycle
//  - 12..(2^SEL_W-1)  y=0, treated like op 0
//  Flags: carry=0 for ops without a listed carry. div0=0 except DIV b==0.
//    zero evaluated on final y only.
//  Flags and y_hi are fully replaced on each completion; nothing is sticky.
// TESTING (WIDTH=8 unless noted)
//  1 rst high during EXEC of MUL, then released -> out_valid=0, in_ready=1, y=0,
//    no spurious out_valid afterwards.
//  2 sel=8 a=0xFF b=0x01, out_ready=1 -> out_valid at N+1; y=0x00, carry=1, zero=1,
//    back in IDLE at N+2.
//  3 sel=10 a=0xFF b=0xFF -> in_ready=0 for 8 cycles; out_valid at N+9; y=0x01, y_hi=0xFE.
//  4 sel=11 a=200 b=7 -> at N+9: y=28, y_hi=4, div0=0; then sel=11 b=0 -> at N+1:
//    y=0xFF, y_hi=a, div0=1.
//  5 out_ready=0 for 5 cycles after completion -> y/flags stable, in_ready=0,
//    in_valid pulses ignored; release -> IDLE next cycle.
//  6 WIDTH=16: sel=9 a=0x0000 b=0x0001 -> y=0xFFFF, carry=1;
//    sel=3 a=0x0001 -> y=0, carry=1, zero=1.

Source files
------------

// File: rtl/seq_alu_module.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_module
// Brief    : Multi-cycle ALU with valid/ready handshakes, registered result,
//            status flags and iterative shift-add MUL / restoring DIV.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu_module #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_div0
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] work_hi_q, work_hi_d;
  logic [WIDTH-1:0] work_lo_q, work_lo_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] y_hi_q, y_hi_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             div0_q, div0_d;

  // Single-cycle op results
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;
  logic [WIDTH:0]   ext_sum;

  always_comb begin
    alu_y   = '0;
    alu_c   = 1'b0;
    ext_sum = '0;
    case (int'(sel))
      1: alu_y = ~a;
      2: begin alu_y = {a[WIDTH-2:0], 1'b0}; alu_c = a[WIDTH-1]; end
      3: begin alu_y = {1'b0, a[WIDTH-1:1]}; alu_c = a[0]; end
      4: begin
        ext_sum = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
        alu_y   = ext_sum[WIDTH-1:0];
        alu_c   = ext_sum[WIDTH];
      end
      5: alu_y = a & b;
      6: alu_y = a | b;
      7: alu_y = a ^ b;
      8: begin
        ext_sum = {1'b0, a} + {1'b0, b};
        alu_y   = ext_sum[WIDTH-1:0];
        alu_c   = ext_sum[WIDTH];
      end
      9: begin
        ext_sum = {1'b0, a} - {1'b0, b};
        alu_y   = ext_sum[WIDTH-1:0];
        alu_c   = ext_sum[WIDTH];
      end
      default: alu_y = '0;
    endcase
  end

  // One iteration: MUL keeps {partial, multiplier}, DIV keeps {remainder, dividend/quotient}
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;

  always_comb begin
    mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    if (is_div_q) begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {work_lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], work_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    opnd_d    = opnd_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    y_d       = y_q;
    y_hi_d    = y_hi_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    div0_d    = div0_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (int'(sel) == 10 || (int'(sel) == 11 && b != '0)) begin
            state_d   = S_EXEC;
            cnt_d     = CNT_W'(WIDTH);
            is_div_d  = (int'(sel) == 11);
            opnd_d    = (int'(sel) == 11) ? b : a;
            work_hi_d = '0;
            work_lo_d = (int'(sel) == 11) ? a : b;
          end else if (int'(sel) == 11) begin
            state_d = S_DONE;
            y_d     = '1;
            y_hi_d  = a;
            zero_d  = 1'b0;
            carry_d = 1'b0;
            div0_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            y_d     = alu_y;
            y_hi_d  = '0;
            zero_d  = (alu_y == '0);
            carry_d = alu_c;
            div0_d  = 1'b0;
          end
        end
      end
      S_EXEC: begin
        work_hi_d = step_hi;
        work_lo_d = step_lo;
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
          y_d     = step_lo;
          y_hi_d  = step_hi;
          zero_d  = (step_lo == '0);
          carry_d = 1'b0;
          div0_d  = 1'b0;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      opnd_q    <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      y_q       <= '0;
      y_hi_q    <= '0;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      opnd_q    <= opnd_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      y_q       <= y_d;
      y_hi_q    <= y_hi_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      div0_q    <= div0_d;
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign y          = y_q;
  assign y_hi       = y_hi_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign flag_div0  = div0_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu_module.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu_module
// Brief    : Directed self-checking bench for seq_alu_module (WIDTH 8 and 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu_module;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] sel = '0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] y, y_hi;
  logic       flag_zero, flag_carry, flag_div0;

  logic        in_valid16 = 1'b0;
  logic        in_ready16;
  logic [3:0]  sel16 = '0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        out_valid16;
  logic        out_ready16 = 1'b0;
  logic [15:0] y16, y_hi16;
  logic        zero16, carry16, div016;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_alu_module #(.WIDTH(8), .SEL_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_hi(y_hi), .flag_zero(flag_zero), .flag_carry(flag_carry),
    .flag_div0(flag_div0)
  );

  seq_alu_module #(.WIDTH(16), .SEL_W(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .sel(sel16), .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
    .y(y16), .y_hi(y_hi16), .flag_zero(zero16), .flag_carry(carry16),
    .flag_div0(div016)
  );

  // Present one operation for exactly one edge, then scramble the inputs
  task automatic issue(input logic [3:0] s, input logic [7:0] aa, input logic [7:0] bb);
    @(negedge clk);
    sel = s; a = aa; b = bb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; sel = ~s; a = ~aa; b = ~bb;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    repeat (2) @(posedge clk); #1;
    tests++;
    if ({in_ready, out_valid, y, y_hi, flag_zero, flag_carry, flag_div0} !== {2'b10, 16'h0, 3'b000}) begin
      fails++;
      $display("FAIL reset_state: rdy=%b vld=%b y=%h yhi=%h z=%b c=%b d=%b", in_ready, out_valid, y, y_hi, flag_zero, flag_carry, flag_div0);
    end
    rst = 1'b0;
    issue(4'd1, 8'h00, 8'h00);
    wait_done(n);
    consume();
    issue(4'd10, 8'hFF, 8'hFF);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    tests++;
    if ({in_ready, out_valid, y, y_hi} !== {2'b10, 16'h0}) begin
      fails++;
      $display("FAIL reset_mid_mul: rdy=%b vld=%b y=%h yhi=%h", in_ready, out_valid, y, y_hi);
    end
    n = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) n++;
    end
    tests++;
    if (n != 0) begin
      fails++;
      $display("FAIL reset_no_spurious: bad_cycles=%0d required 0", n);
    end
  endtask

  task automatic test_add_carry();
    int n;
    out_ready = 1'b1;
    issue(4'd8, 8'hFF, 8'h01);
    tests++;
    if ({out_valid, y, flag_carry, flag_zero, flag_div0} !== {1'b1, 8'h00, 3'b110}) begin
      fails++;
      $display("FAIL add_wrap: vld=%b y=%h c=%b z=%b d=%b required 1 00 1 1 0", out_valid, y, flag_carry, flag_zero, flag_div0);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      fails++;
      $display("FAIL add_return_idle: rdy=%b vld=%b required 1 0", in_ready, out_valid);
    end
    n = 0;
  endtask

  task automatic test_ops();
    logic [3:0] s_t [14] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd9, 4'd13, 4'd15};
    logic [7:0] a_t [14] = '{8'h5A, 8'h5A, 8'h81, 8'h81, 8'hFF, 8'h7F, 8'h5A, 8'h5A, 8'h5A, 8'h80, 8'h10, 8'h20, 8'h5A, 8'hFF};
    logic [7:0] b_t [14] = '{8'h33, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h33, 8'h33, 8'h33, 8'h7F, 8'h20, 8'h10, 8'h33, 8'hFF};
    logic [7:0] y_t [14] = '{8'h00, 8'hA5, 8'h02, 8'h40, 8'h00, 8'h80, 8'h12, 8'h7B, 8'h69, 8'hFF, 8'hF0, 8'h10, 8'h00, 8'h00};
    logic       c_t [14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int n;
    for (int i = 0; i < 14; i++) begin
      issue(s_t[i], a_t[i], b_t[i]);
      wait_done(n);
      tests++;
      if (n != 0 || {y, y_hi, flag_carry, flag_zero, flag_div0} !== {y_t[i], 8'h00, c_t[i], (y_t[i] == 8'h00), 1'b0}) begin
        fails++;
        $display("FAIL op_sel%0d: lat=%0d y=%h yhi=%h c=%b z=%b d=%b required lat=0 y=%h c=%b", s_t[i], n, y, y_hi, flag_carry, flag_zero, flag_div0, y_t[i], c_t[i]);
      end
      consume();
    end
  endtask

  task automatic test_mul();
    logic [7:0] a_t [3] = '{8'hFF, 8'h0D, 8'h80};
    logic [7:0] b_t [3] = '{8'hFF, 8'h0B, 8'h02};
    logic [15:0] p_t [3] = '{16'hFE01, 16'h008F, 16'h0100};
    int n;
    int busy;
    for (int i = 0; i < 3; i++) begin
      issue(4'd10, a_t[i], b_t[i]);
      busy = 0;
      for (int k = 0; k < 8; k++) begin
        if (in_ready === 1'b0 && out_valid === 1'b0) busy++;
        @(posedge clk); #1;
      end
      tests++;
      if (busy != 8 || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL mul_latency_%0d: busy_cycles=%0d vld=%b required 8 1", i, busy, out_valid);
      end
      wait_done(n);
      tests++;
      if ({y_hi, y, flag_zero, flag_carry, flag_div0} !== {p_t[i], (p_t[i][7:0] == 8'h00), 2'b00}) begin
        fails++;
        $display("FAIL mul_result_%0d: hi=%h y=%h z=%b c=%b d=%b required %h", i, y_hi, y, flag_zero, flag_carry, flag_div0, p_t[i]);
      end
      consume();
    end
  endtask

  task automatic test_div();
    logic [7:0] a_t [3] = '{8'd200, 8'd5, 8'd255};
    logic [7:0] b_t [3] = '{8'd7, 8'd9, 8'd1};
    logic [7:0] q_t [3] = '{8'd28, 8'd0, 8'd255};
    logic [7:0] r_t [3] = '{8'd4, 8'd5, 8'd0};
    int n;
    for (int i = 0; i < 3; i++) begin
      issue(4'd11, a_t[i], b_t[i]);
      wait_done(n);
      tests++;
      if (n != 8 || {y, y_hi, flag_zero, flag_div0} !== {q_t[i], r_t[i], (q_t[i] == 8'h00), 1'b0}) begin
        fails++;
        $display("FAIL div_%0d: lat=%0d q=%h r=%h z=%b d=%b required lat=8 q=%h r=%h", i, n, y, y_hi, flag_zero, flag_div0, q_t[i], r_t[i]);
      end
      consume();
    end
    issue(4'd11, 8'd200, 8'd0);
    wait_done(n);
    tests++;
    if (n != 0 || {y, y_hi, flag_div0, flag_zero, flag_carry} !== {8'hFF, 8'd200, 3'b100}) begin
      fails++;
      $display("FAIL div_by_zero: lat=%0d y=%h yhi=%h d=%b z=%b c=%b required lat=0 ff c8 1 0 0", n, y, y_hi, flag_div0, flag_zero, flag_carry);
    end
    consume();
  endtask

  task automatic test_hold();
    int n;
    int bad;
    issue(4'd7, 8'hF0, 8'h0F);
    wait_done(n);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = k[0]; sel = 4'd0; a = 8'h00; b = 8'h00;
      @(posedge clk); #1;
      if ({out_valid, in_ready, y, y_hi, flag_zero, flag_carry, flag_div0} !== {2'b10, 8'hFF, 8'h00, 3'b000}) bad++;
    end
    in_valid = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL hold_stable: bad_cycles=%0d required 0 (y=%h)", bad, y);
    end
    consume();
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      fails++;
      $display("FAIL hold_release: rdy=%b vld=%b required 1 0", in_ready, out_valid);
    end
    @(posedge clk); #1;
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      fails++;
      $display("FAIL hold_no_accept: rdy=%b vld=%b required 1 0", in_ready, out_valid);
    end
  endtask

  // Flags and y_hi must be fully replaced by the next completion
  task automatic test_back_to_back();
    int n;
    issue(4'd11, 8'd9, 8'd0);
    wait_done(n);
    consume();
    issue(4'd6, 8'h01, 8'h02);
    wait_done(n);
    tests++;
    if ({y, y_hi, flag_div0, flag_carry, flag_zero} !== {8'h03, 8'h00, 3'b000}) begin
      fails++;
      $display("FAIL b2b_after_div0: y=%h yhi=%h d=%b c=%b z=%b required 03 00 0 0 0", y, y_hi, flag_div0, flag_carry, flag_zero);
    end
    consume();
    issue(4'd10, 8'h10, 8'h10);
    wait_done(n);
    consume();
    issue(4'd2, 8'h80, 8'h00);
    wait_done(n);
    tests++;
    if ({y, y_hi, flag_carry, flag_zero} !== {8'h00, 8'h00, 2'b11}) begin
      fails++;
      $display("FAIL b2b_after_mul: y=%h yhi=%h c=%b z=%b required 00 00 1 1", y, y_hi, flag_carry, flag_zero);
    end
    consume();
  endtask

  task automatic test_w16();
    logic [3:0]  s_t [3] = '{4'd9, 4'd3, 4'd10};
    logic [15:0] a_t [3] = '{16'h0000, 16'h0001, 16'h1234};
    logic [15:0] b_t [3] = '{16'h0001, 16'h0000, 16'h0100};
    logic [31:0] r_t [3] = '{32'h0000FFFF, 32'h00000000, 32'h00123400};
    logic        c_t [3] = '{1'b1, 1'b1, 1'b0};
    int          l_t [3] = '{0, 0, 16};
    int n;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sel16 = s_t[i]; a16 = a_t[i]; b16 = b_t[i]; in_valid16 = 1'b1;
      @(posedge clk); #1;
      in_valid16 = 1'b0; a16 = ~a_t[i]; b16 = ~b_t[i];
      n = 0;
      while (out_valid16 !== 1'b1 && n < 64) begin
        @(posedge clk); #1;
        n++;
      end
      tests++;
      if (n != l_t[i] || {y_hi16, y16, carry16, zero16} !== {r_t[i], c_t[i], (r_t[i][15:0] == 16'h0)}) begin
        fails++;
        $display("FAIL w16_sel%0d: lat=%0d hi=%h y=%h c=%b z=%b required lat=%0d %h c=%b", s_t[i], n, y_hi16, y16, carry16, zero16, l_t[i], r_t[i], c_t[i]);
      end
      out_ready16 = 1'b1;
      @(posedge clk); #1;
      out_ready16 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_add_carry();
    test_ops();
    test_mul();
    test_div();
    test_hold();
    test_back_to_back();
    test_w16();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
